// File: rtl/sym_word_packer.sv
// sym_word_packer
// Packs the HS receive symbol stream into 7-symbol (21-bit) words. Packing runs
// between a sync detection (after a preamble) and a post detection. A completed
// group is staged for one cycle so that a sync or post detection that lands just
// after the group can still discard it.
//
// Ports:
//   RxSymClkHs   in   1   HS symbol clock, rising edge
//   Rst          in   1   synchronous active-high reset
//   RxSymbol     in   3   received symbol, one per cycle
//   DetectedSeq  in   4   one-hot detector event: 0001 pre, 0010 sync, 0100 post
//   syncErr      in   1   sync-word error, qualified by DetectedSeq==0010
//   WordSym      out  21  packed group, first symbol in [20:18]
//   WordValid    out  1   one-cycle strobe qualifying WordSym
//   RxActiveHS   out  1   registered (state==DATA), one cycle behind the state
//   WordCnt      out  16  words emitted in the current burst, saturating
//   AlignErr     out  1   pulse on post detection with a partial group
//   SyncFail     out  1   pulse on sync detection with syncErr
module sym_word_packer (
   input  logic        RxSymClkHs,
   input  logic        Rst,
   input  logic [2:0]  RxSymbol,
   input  logic [3:0]  DetectedSeq,
   input  logic        syncErr,
   output logic [20:0] WordSym,
   output logic        WordValid,
   output logic        RxActiveHS,
   output logic [15:0] WordCnt,
   output logic        AlignErr,
   output logic        SyncFail
);

   localparam int unsigned SymW    = 3;
   localparam int unsigned GrpSyms = 7;
   localparam int unsigned WordW   = SymW * GrpSyms;
   localparam int unsigned CntW    = 16;
   localparam int unsigned SymCntW = 3;

   localparam logic [3:0] SeqNone = 4'b0000;
   localparam logic [3:0] SeqPre  = 4'b0001;
   localparam logic [3:0] SeqSync = 4'b0010;
   localparam logic [3:0] SeqPost = 4'b0100;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      DATA  = 2'd2
   } stateT;

   stateT               state, stateNext;
   logic [SymCntW-1:0]  symCnt, symCntNext;
   logic [WordW-1:0]    group, groupNext;
   logic [WordW-1:0]    staged, stagedNext;
   logic                stagedVld, stagedVldNext;
   logic [WordW-1:0]    wordSymNext;
   logic                wordValidNext;
   logic [CntW-1:0]     wordCntNext;
   logic                alignErrNext;
   logic                syncFailNext;

   logic isNone, isPre, isSync, isPost;

   assign isNone = (DetectedSeq == SeqNone);
   assign isPre  = (DetectedSeq == SeqPre);
   assign isSync = (DetectedSeq == SeqSync);
   assign isPost = (DetectedSeq == SeqPost);

   // Next-state and next-output logic.
   always_comb begin
      stateNext     = state;
      symCntNext    = symCnt;
      groupNext     = group;
      stagedNext    = staged;
      stagedVldNext = 1'b0;
      wordSymNext   = WordSym;
      wordValidNext = 1'b0;
      wordCntNext   = WordCnt;
      alignErrNext  = 1'b0;
      syncFailNext  = 1'b0;

      case (state)
         IDLE: begin
            if (isPre) begin
               stateNext   = ARMED;
               wordCntNext = '0;
            end
         end

         ARMED: begin
            if (isSync) begin
               if (syncErr) begin
                  syncFailNext = 1'b1;
                  stateNext    = IDLE;
               end else begin
                  stateNext  = DATA;
                  groupNext  = WordW'(RxSymbol);
                  symCntNext = SymCntW'(1);
               end
            end
         end

         DATA: begin
            if (isPost) begin
               // A staged (complete) group is silently dropped; a partial one is an error.
               alignErrNext = ~stagedVld;
               symCntNext   = '0;
               stateNext    = IDLE;
            end else if (isSync) begin
               // Realign: the current symbol starts a fresh group.
               groupNext    = WordW'(RxSymbol);
               symCntNext   = SymCntW'(1);
               syncFailNext = syncErr;
            end else begin
               if (stagedVld && (isNone || isPre)) begin
                  wordSymNext   = staged;
                  wordValidNext = 1'b1;
                  if (WordCnt != {CntW{1'b1}})
                     wordCntNext = WordCnt + CntW'(1);
               end
               groupNext = {group[WordW-SymW-1:0], RxSymbol};
               if (symCnt == SymCntW'(GrpSyms - 1)) begin
                  stagedNext    = groupNext;
                  stagedVldNext = 1'b1;
                  symCntNext    = '0;
               end else begin
                  symCntNext = symCnt + SymCntW'(1);
               end
            end
         end

         default: begin
            stateNext  = IDLE;
            symCntNext = '0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge RxSymClkHs) begin
      if (Rst) begin
         state      <= IDLE;
         symCnt     <= '0;
         group      <= '0;
         staged     <= '0;
         stagedVld  <= 1'b0;
         WordSym    <= '0;
         WordValid  <= 1'b0;
         RxActiveHS <= 1'b0;
         WordCnt    <= '0;
         AlignErr   <= 1'b0;
         SyncFail   <= 1'b0;
      end else begin
         state      <= stateNext;
         symCnt     <= symCntNext;
         group      <= groupNext;
         staged     <= stagedNext;
         stagedVld  <= stagedVldNext;
         WordSym    <= wordSymNext;
         WordValid  <= wordValidNext;
         RxActiveHS <= (state == DATA);
         WordCnt    <= wordCntNext;
         AlignErr   <= alignErrNext;
         SyncFail   <= syncFailNext;
      end
   end

endmodule

// File: tb/tb_sym_word_packer.sv
// tb_sym_word_packer
// Directed scenarios plus randomized bursts for sym_word_packer. A per-cycle
// reference model built on a symbol queue predicts every output.
module tb_sym_word_packer;

   logic        RxSymClkHs;
   logic        Rst;
   logic [2:0]  RxSymbol;
   logic [3:0]  DetectedSeq;
   logic        syncErr;
   logic [20:0] WordSym;
   logic        WordValid;
   logic        RxActiveHS;
   logic [15:0] WordCnt;
   logic        AlignErr;
   logic        SyncFail;

   sym_word_packer dut (
      .RxSymClkHs (RxSymClkHs),
      .Rst        (Rst),
      .RxSymbol   (RxSymbol),
      .DetectedSeq(DetectedSeq),
      .syncErr    (syncErr),
      .WordSym    (WordSym),
      .WordValid  (WordValid),
      .RxActiveHS (RxActiveHS),
      .WordCnt    (WordCnt),
      .AlignErr   (AlignErr),
      .SyncFail   (SyncFail)
   );

   initial RxSymClkHs = 1'b0;
   always #5 RxSymClkHs = ~RxSymClkHs;

   localparam logic [20:0] PRE_G  = 21'o3333333;
   localparam logic [20:0] SYNC_G = 21'o3444443;
   localparam logic [20:0] POST_G = 21'o4444444;
   localparam logic [20:0] DATA_A = 21'o2106502;

   int checks;
   int errors;
   int cyc;

   // Reference model state
   bit          mArmed, mBurst, mPend;
   int unsigned q[$];
   int unsigned mPendWord;
   int unsigned eWordSym, eCnt;
   bit          eValid, eActive, eAlign, eFail;

   // Observations for scenario-level checks
   int          obsValid, obsAlign, obsFail, validCyc;
   logic [20:0] obsLastWord;
   bit          prevValid;

   logic [3:0]  pendDet;
   logic        pendErr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc %0d observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic modelEdge(input logic r, input logic [2:0] s, input logic [3:0] d, input logic e);
      bit pend;
      int unsigned w;
      pend   = mPend;
      mPend  = 0;
      eValid = 0;
      eAlign = 0;
      eFail  = 0;
      if (r) begin
         mArmed = 0; mBurst = 0; q.delete();
         eWordSym = 0; eCnt = 0; eActive = 0;
      end else begin
         eActive = mBurst;
         if (mBurst) begin
            if (d == 4'b0100) begin
               eAlign = !pend;
               q.delete();
               mBurst = 0;
            end else if (d == 4'b0010) begin
               q.delete();
               q.push_back(32'(s));
               eFail = e;
            end else begin
               if (pend && (d == 4'b0000 || d == 4'b0001)) begin
                  eValid   = 1;
                  eWordSym = mPendWord;
                  if (eCnt < 65535) eCnt++;
               end
               q.push_back(32'(s));
               if (q.size() == 7) begin
                  w = 0;
                  foreach (q[i]) w = w * 8 + q[i];
                  mPendWord = w;
                  mPend     = 1;
                  q.delete();
               end
            end
         end else if (mArmed) begin
            if (d == 4'b0010) begin
               mArmed = 0;
               if (e) eFail = 1;
               else begin
                  mBurst = 1;
                  q.delete();
                  q.push_back(32'(s));
               end
            end
         end else if (d == 4'b0001) begin
            mArmed = 1;
            eCnt   = 0;
         end
      end
   endtask

   task automatic step(input logic r, input logic [2:0] s, input logic [3:0] d, input logic e);
      Rst = r; RxSymbol = s; DetectedSeq = d; syncErr = e;
      @(posedge RxSymClkHs);
      modelEdge(r, s, d, e);
      #1;
      cyc++;
      if (WordValid) begin obsValid++; obsLastWord = WordSym; validCyc = cyc; end
      if (AlignErr) obsAlign++;
      if (SyncFail) obsFail++;
      chk("WordValid",  32'(WordValid),  32'(eValid));
      chk("WordSym",    32'(WordSym),    eWordSym);
      chk("WordCnt",    32'(WordCnt),    eCnt);
      chk("RxActiveHS", 32'(RxActiveHS), 32'(eActive));
      chk("AlignErr",   32'(AlignErr),   32'(eAlign));
      chk("SyncFail",   32'(SyncFail),   32'(eFail));
      chk("backToBack", 32'(prevValid & WordValid), 32'd0);
      prevValid = WordValid;
   endtask

   // One symbol carrying any pending detector event.
   task automatic sym1(input logic [2:0] s);
      logic [3:0] d;
      logic       e;
      d = pendDet; e = pendErr;
      pendDet = 4'b0000; pendErr = 1'b0;
      step(1'b0, s, d, e);
   endtask

   task automatic sendSyms(input logic [20:0] g, input int n);
      for (int i = n - 1; i >= 0; i--) sym1(g[3*i +: 3]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) sym1(3'($urandom_range(0, 7)));
   endtask

   task automatic sendPre();
      sendSyms(PRE_G, 7);
      pendDet = 4'b0001;
   endtask

   task automatic sendSync(input logic err);
      sendSyms(SYNC_G, 7);
      pendDet = 4'b0010;
      pendErr = err;
   endtask

   task automatic sendPost();
      sendSyms(POST_G, 7);
      pendDet = 4'b0100;
   endtask

   task automatic clrObs();
      obsValid = 0; obsAlign = 0; obsFail = 0; validCyc = -1;
   endtask

   initial begin
      int dataEnd, nd, r;
      checks = 0; errors = 0; cyc = 0;
      mArmed = 0; mBurst = 0; mPend = 0; mPendWord = 0;
      eWordSym = 0; eCnt = 0; eValid = 0; eActive = 0; eAlign = 0; eFail = 0;
      prevValid = 0; obsLastWord = '0;
      pendDet = 4'b0000; pendErr = 1'b0;
      Rst = 1'b1; RxSymbol = '0; DetectedSeq = '0; syncErr = 1'b0;
      clrObs();

      // Reset state
      step(1'b1, 3'd0, 4'b0001, 1'b0);
      step(1'b1, 3'd5, 4'b0010, 1'b0);
      chk("rstWordSym", 32'(WordSym), 32'd0);
      chk("rstWordCnt", 32'(WordCnt), 32'd0);
      idle(2);

      // Normal burst
      clrObs();
      sendPre(); sendSync(1'b0);
      sendSyms(DATA_A, 7);
      dataEnd = cyc;
      sendPost(); idle(3);
      chk("burstWords",   32'(obsValid),    32'd1);
      chk("burstWordSym", 32'(obsLastWord), 32'h088D42);
      chk("burstLatency", 32'(validCyc),    32'(dataEnd + 1));
      chk("burstWordCnt", 32'(WordCnt),     32'd1);
      chk("burstActive",  32'(RxActiveHS),  32'd0);
      chk("burstAlign",   32'(obsAlign),    32'd0);

      // Sync error, then a sync with no preamble must be ignored
      clrObs();
      sendPre();
      sendSyms(21'o34443, 5);
      pendDet = 4'b0010; pendErr = 1'b1;
      idle(3);
      chk("syncErrFail",  32'(obsFail),  32'd1);
      chk("syncErrWords", 32'(obsValid), 32'd0);
      sendSync(1'b0);
      sendSyms(DATA_A, 7); idle(4);
      chk("noPreWords",  32'(obsValid),   32'd0);
      chk("noPreActive", 32'(RxActiveHS), 32'd0);

      // Mid-burst sync
      clrObs();
      sendPre(); sendSync(1'b0);
      sendSyms(DATA_A, 7);
      sendSync(1'b0);
      sendSyms(DATA_A, 7);
      sendPost(); idle(3);
      chk("midWords",   32'(obsValid),    32'd2);
      chk("midWordSym", 32'(obsLastWord), 32'h088D42);
      chk("midWordCnt", 32'(WordCnt),     32'd2);
      chk("midFail",    32'(obsFail),     32'd0);

      // Misaligned post
      clrObs();
      sendPre(); sendSync(1'b0);
      sendSyms(21'o2106, 4);
      pendDet = 4'b0100;
      idle(3);
      chk("misAlign",  32'(obsAlign),   32'd1);
      chk("misWords",  32'(obsValid),   32'd0);
      chk("misActive", 32'(RxActiveHS), 32'd0);

      // Reset mid-burst
      clrObs();
      sendPre(); sendSync(1'b0);
      sendSyms(21'o210, 3);
      step(1'b1, 3'd6, 4'b0100, 1'b0);
      chk("midRstWordSym", 32'(WordSym),    32'd0);
      chk("midRstValid",   32'(WordValid),  32'd0);
      chk("midRstActive",  32'(RxActiveHS), 32'd0);
      chk("midRstWordCnt", 32'(WordCnt),    32'd0);
      chk("midRstFlags",   32'({AlignErr, SyncFail}), 32'd0);
      idle(3);
      chk("midRstNoWord", 32'(obsValid), 32'd0);
      sendPre(); sendSync(1'b0);
      sendSyms(DATA_A, 7);
      sendPost(); idle(3);
      chk("postRstWordSym", 32'(obsLastWord), 32'h088D42);
      chk("postRstWordCnt", 32'(WordCnt),     32'd1);

      // Randomized bursts
      for (int b = 0; b < 30; b++) begin
         sendPre();
         sendSync(1'($urandom_range(0, 7) == 0));
         nd = $urandom_range(0, 30);
         for (int i = 0; i < nd; i++) sym1(3'($urandom_range(0, 7)));
         if ($urandom_range(0, 3) == 0) begin
            sendSync(1'b0);
            nd = $urandom_range(1, 20);
            for (int i = 0; i < nd; i++) sym1(3'($urandom_range(0, 7)));
         end
         sendPost();
         idle($urandom_range(1, 4));
      end

      // Free-running random detector events and occasional resets
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 15);
         step(1'($urandom_range(0, 63) == 0),
              3'($urandom_range(0, 7)),
              (r < 10) ? 4'b0000 : (r < 12) ? 4'b0001 : (r < 15) ? 4'b0010 : 4'b0100,
              1'($urandom_range(0, 5) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
